// File: rtl/bus_cycle_arbiter_pkg.sv
// rtl/bus_cycle_arbiter_pkg.sv - shared state encoding and constants for the bus cycle arbiter
// Purpose: one place for the arbiter state encoding and sizing constants.
// Ports:   none (package).
package bus_cycle_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_CPU_OWN   = 2'd0,
        ARB_HALT_PEND = 2'd1,
        ARB_DMA_OWN   = 2'd2,
        ARB_COOLDOWN  = 2'd3
    } arb_state_e;

    localparam int ARB_MAX_BURST_DEFAULT = 8;
    localparam int ARB_BURST_W           = 4;   // holds burst lengths up to 15
    localparam int ARB_STOLEN_W          = 16;

endpackage

// File: rtl/bus_cycle_arbiter_if.sv
// rtl/bus_cycle_arbiter_if.sv - CPU/DMA/memory bus bundle seen by the arbiter
// Purpose: groups the CPU, DMA and memory-map signals around the arbiter.
// Ports:   slave modport  = arbiter side (CPU/DMA/mem inputs, grant/mux outputs)
//          master modport = system side (drives CPU/DMA/mem, observes arbiter)
interface bus_cycle_arbiter_if;

    logic        phi_tick;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic [7:0]  mem_rdata;
    logic        cpu_rdy;
    logic        dma_grant;
    logic        dma_valid;
    logic [7:0]  dma_data;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [15:0] stolen_cycles;

    modport slave (
        input  phi_tick, cpu_addr, cpu_we, cpu_wdata, dma_req, dma_addr, mem_rdata,
        output cpu_rdy, dma_grant, dma_valid, dma_data, mem_addr, mem_we, mem_wdata,
               stolen_cycles
    );

    modport master (
        output phi_tick, cpu_addr, cpu_we, cpu_wdata, dma_req, dma_addr, mem_rdata,
        input  cpu_rdy, dma_grant, dma_valid, dma_data, mem_addr, mem_we, mem_wdata,
               stolen_cycles
    );

endinterface

// File: rtl/bus_cycle_arbiter_sat_counter.sv
// rtl/bus_cycle_arbiter_sat_counter.sv - saturating incrementer with enable
// Purpose: counts enabled clocks, sticking at all-ones instead of wrapping.
// Ports:   clk, rst (async, active-high), en_i (count this clock), count_o (current value)
module arb_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bus_cycle_arbiter.sv
// rtl/bus_cycle_arbiter.sv - steals 6502 bus cycles for a video DMA engine
// Purpose: decides, once per CPU bus cycle (at phi_tick), whether the CPU or
//          the DMA engine owns the memory bus, stalls the CPU via cpu_rdy,
//          latches DMA read data and counts stolen cycles.
// Ports:   clk, rst (async, active-high), bus (slave modport of bus_cycle_arbiter_if)
// Params:  MAX_BURST (1..15) DMA cycles in a row before the CPU gets one cycle
module bus_cycle_arbiter
    import bus_cycle_arbiter_pkg::*;
#(
    parameter int MAX_BURST = ARB_MAX_BURST_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    bus_cycle_arbiter_if.slave bus
);

    localparam logic [ARB_BURST_W-1:0] BURST_LAST = ARB_BURST_W'(MAX_BURST);

    arb_state_e             state_q, state_d;
    logic [ARB_BURST_W-1:0] burst_q, burst_d;
    logic [7:0]             dma_data_q, dma_data_d;
    logic                   dma_valid_q, dma_valid_d;
    logic [ARB_BURST_W-1:0] burst_inc;
    logic                   dma_done;
    logic                   dma_grant;

    // A tick seen while DMA owns the bus closes a completed DMA read.
    assign dma_done  = bus.phi_tick && (state_q == ARB_DMA_OWN);
    assign burst_inc = burst_q + ARB_BURST_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_CPU_OWN;
            burst_q     <= '0;
            dma_data_q  <= 8'h00;
            dma_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            dma_data_q  <= dma_data_d;
            dma_valid_q <= dma_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        dma_data_d  = dma_data_q;
        dma_valid_d = 1'b0;
        if (bus.phi_tick) begin
            case (state_q)
                // CPU_OWN, HALT_PEND and COOLDOWN share one exit rule. COOLDOWN
                // ignores dma_req only during its own bus cycle, which it does
                // simply by lasting exactly one tick-to-tick cycle. A write
                // cycle cannot be stalled, so a request during one waits in
                // HALT_PEND until the CPU issues a read.
                ARB_CPU_OWN, ARB_HALT_PEND, ARB_COOLDOWN: begin
                    if (bus.dma_req) begin
                        state_d = bus.cpu_we ? ARB_HALT_PEND : ARB_DMA_OWN;
                    end else begin
                        state_d = ARB_CPU_OWN;
                    end
                end
                ARB_DMA_OWN: begin
                    dma_valid_d = 1'b1;
                    dma_data_d  = bus.mem_rdata;
                    if (!bus.dma_req) begin
                        state_d = ARB_CPU_OWN;
                        burst_d = '0;
                    end else if (burst_inc == BURST_LAST) begin
                        state_d = ARB_COOLDOWN;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_inc;
                    end
                end
                default: begin
                    state_d = ARB_CPU_OWN;
                    burst_d = '0;
                end
            endcase
        end
    end

    arb_sat_counter #(
        .WIDTH (ARB_STOLEN_W)
    ) u_stolen (
        .clk     (clk),
        .rst     (rst),
        .en_i    (dma_done),
        .count_o (bus.stolen_cycles)
    );

    // Bus outputs decode straight from the state register so reset returns
    // the bus to the CPU without waiting for a clock edge.
    assign dma_grant     = (state_q == ARB_DMA_OWN);
    assign bus.dma_grant = dma_grant;
    assign bus.cpu_rdy   = (state_q == ARB_CPU_OWN) || (state_q == ARB_COOLDOWN);
    assign bus.mem_addr  = dma_grant ? bus.dma_addr : bus.cpu_addr;
    assign bus.mem_we    = bus.cpu_we && !dma_grant;
    assign bus.mem_wdata = bus.cpu_wdata;
    assign bus.dma_valid = dma_valid_q;
    assign bus.dma_data  = dma_data_q;

endmodule
